// File: rtl/alu_clmul_iter.sv
// Iterative carry-less multiplier (CLMUL / CLMULH / CLMULR) for the execute stage.
// Consumes BITS_PER_CYCLE bits of B per cycle and stops once the remaining B bits are zero.
module alu_clmul_iter #(
    parameter int unsigned XLEN           = 64,
    parameter int unsigned BITS_PER_CYCLE = 8,
    parameter int unsigned TRANS_ID_BITS  = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [1:0]               op_i,
    input  logic [XLEN-1:0]          operand_a_i,
    input  logic [XLEN-1:0]          operand_b_i,
    input  logic [TRANS_ID_BITS-1:0] trans_id_i,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [XLEN-1:0]          result_o,
    output logic [TRANS_ID_BITS-1:0] trans_id_o
);

    localparam int unsigned NCHUNK = XLEN / BITS_PER_CYCLE;
    localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int unsigned PW     = 2 * XLEN;

    localparam logic [1:0] OP_CLMUL  = 2'd0;
    localparam logic [1:0] OP_CLMULH = 2'd1;
    localparam logic [1:0] OP_CLMULR = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                   state_q;
    logic [PW-1:0]            a_q;       // A pre-shifted to the current chunk position
    logic [XLEN-1:0]          b_q;       // B bits not yet consumed, current chunk in LSBs
    logic [1:0]               op_q;
    logic [TRANS_ID_BITS-1:0] tag_q;
    logic [PW-1:0]            acc_q;
    logic [CNT_W-1:0]         cnt_q;
    logic                     valid_q;
    logic [XLEN-1:0]          result_q;

    logic [PW-1:0]            partial;
    logic [PW-1:0]            acc_d;
    logic [XLEN-1:0]          b_rest;
    logic                     last_chunk;
    logic [XLEN-1:0]          slice_d;

    // Fold the current chunk of B into the accumulator and pick the result slice.
    always_comb begin
        partial = '0;
        for (int unsigned k = 0; k < BITS_PER_CYCLE; k++) begin
            if (b_q[k]) begin
                partial = partial ^ (a_q << k);
            end
        end
        acc_d      = acc_q ^ partial;
        b_rest     = b_q >> BITS_PER_CYCLE;
        last_chunk = (cnt_q == CNT_W'(NCHUNK - 1)) || (b_rest == '0);
        case (op_q)
            OP_CLMUL:  slice_d = acc_d[XLEN-1:0];
            OP_CLMULH: slice_d = acc_d[PW-1:XLEN];
            OP_CLMULR: slice_d = acc_d[PW-2:XLEN-1];
            default:   slice_d = '0;
        endcase
    end

    // Control FSM and datapath registers; flush wins over everything except reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            tag_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else if (flush_i) begin
            state_q  <= IDLE;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        a_q     <= PW'(operand_a_i);
                        b_q     <= operand_b_i;
                        op_q    <= op_i;
                        tag_q   <= trans_id_i;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    acc_q <= acc_d;
                    a_q   <= a_q << BITS_PER_CYCLE;
                    b_q   <= b_rest;
                    if (last_chunk) begin
                        state_q  <= DONE;
                        valid_q  <= 1'b1;
                        result_q <= slice_d;
                    end else begin
                        cnt_q <= CNT_W'(cnt_q + 1'b1);
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        state_q  <= IDLE;
                        valid_q  <= 1'b0;
                        result_q <= '0;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    valid_q  <= 1'b0;
                    result_q <= '0;
                end
            endcase
        end
    end

    assign ready_o    = (state_q == IDLE);
    assign valid_o    = valid_q;
    assign result_o   = result_q;
    assign trans_id_o = tag_q;

endmodule

// File: tb/tb_alu_clmul_iter.sv
// Self-checking bench for alu_clmul_iter with a plain-arithmetic carry-less product model.
module tb_alu_clmul_iter;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned BPC    = 8;
    localparam int unsigned NCHUNK = XLEN / BPC;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        flush_i;
    logic        valid_i;
    logic        ready_o;
    logic [1:0]  op_i;
    logic [63:0] operand_a_i;
    logic [63:0] operand_b_i;
    logic [2:0]  trans_id_i;
    logic        valid_o;
    logic        ready_i;
    logic [63:0] result_o;
    logic [2:0]  trans_id_o;

    int vectors     = 0;
    int miscompares = 0;

    alu_clmul_iter #(
        .XLEN(XLEN),
        .BITS_PER_CYCLE(BPC),
        .TRANS_ID_BITS(3)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (flush_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .op_i       (op_i),
        .operand_a_i(operand_a_i),
        .operand_b_i(operand_b_i),
        .trans_id_i (trans_id_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .result_o   (result_o),
        .trans_id_o (trans_id_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // Carry-less product straight from the definition, then the op's slice.
    function automatic logic [63:0] ref_res(input logic [1:0] op, input logic [63:0] a,
                                            input logic [63:0] b);
        logic [127:0] p;
        p = '0;
        for (int i = 0; i < 64; i++) begin
            if (b[i]) p = p ^ ({64'd0, a} << i);
        end
        case (op)
            2'd0:    return p[63:0];
            2'd1:    return p[127:64];
            2'd2:    return p[126:63];
            default: return 64'd0;
        endcase
    endfunction

    // Latency = index of highest nonzero chunk of B plus one, at least 1.
    function automatic int ref_lat(input logic [63:0] b);
        int l;
        l = 1;
        for (int c = 0; c < int'(NCHUNK); c++) begin
            if (((b >> (c * BPC)) & 64'hFF) != 64'd0) l = c + 1;
        end
        return l;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op, wait (bounded) for the result, hold backpressure, then retire it.
    task automatic run_op(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic [2:0] tid, input int hold, input string tag);
        logic [63:0] exp;
        int          l_exp;
        int          lat;
        exp   = ref_res(op, a, b);
        l_exp = ref_lat(b);
        chk({tag, "/ready_before"}, 64'(ready_o), 64'd1);
        valid_i     = 1'b1;
        op_i        = op;
        operand_a_i = a;
        operand_b_i = b;
        trans_id_i  = tid;
        @(posedge clk_i); #1;
        valid_i     = 1'b0;
        lat         = 0;
        while (!valid_o && lat < int'(NCHUNK) + 4) begin
            op_i        = 2'($urandom);
            operand_a_i = {$urandom, $urandom};
            operand_b_i = {$urandom, $urandom};
            trans_id_i  = 3'($urandom);
            ready_i     = 1'($urandom);
            @(posedge clk_i); #1;
            lat++;
        end
        ready_i = 1'b0;
        chk({tag, "/latency"}, 64'(lat), 64'(l_exp));
        chk({tag, "/valid"}, 64'(valid_o), 64'd1);
        chk({tag, "/result"}, result_o, exp);
        chk({tag, "/trans_id"}, 64'(trans_id_o), 64'(tid));
        chk({tag, "/ready_busy"}, 64'(ready_o), 64'd0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk_i); #1;
            chk({tag, "/hold_valid"}, 64'(valid_o), 64'd1);
            chk({tag, "/hold_result"}, result_o, exp);
            chk({tag, "/hold_tid"}, 64'(trans_id_o), 64'(tid));
            chk({tag, "/hold_ready"}, 64'(ready_o), 64'd0);
        end
        ready_i = 1'b1;
        @(posedge clk_i); #1;
        ready_i = 1'b0;
        chk({tag, "/valid_after"}, 64'(valid_o), 64'd0);
        chk({tag, "/result_after"}, result_o, 64'd0);
        chk({tag, "/ready_after"}, 64'(ready_o), 64'd1);
    endtask

    initial begin
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] mask;
        rst_ni      = 1'b0;
        flush_i     = 1'b0;
        valid_i     = 1'b0;
        op_i        = 2'd0;
        operand_a_i = '0;
        operand_b_i = '0;
        trans_id_i  = '0;
        ready_i     = 1'b0;

        #3;
        chk("reset/valid", 64'(valid_o), 64'd0);
        chk("reset/result", result_o, 64'd0);
        chk("reset/tid", 64'(trans_id_o), 64'd0);
        chk("reset/ready", 64'(ready_o), 64'd1);
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // Directed cases
        run_op(2'd0, 64'h3, 64'h3, 3'd5, 0, "clmul_small");
        run_op(2'd1, '1, '1, 3'd1, 0, "clmulh_ones");
        run_op(2'd0, '1, '1, 3'd2, 0, "clmul_ones");
        run_op(2'd2, '1, '1, 3'd3, 0, "clmulr_ones");
        run_op(2'd0, 64'h8000_0000_0000_0001, 64'h0100_0000_0000_0000, 3'd4, 0, "clmul_top");
        run_op(2'd1, 64'h8000_0000_0000_0001, 64'h0100_0000_0000_0000, 3'd6, 0, "clmulh_top");
        run_op(2'd3, '1, '1, 3'd7, 0, "reserved_op");
        run_op(2'd2, 64'h1234_5678_9abc_def0, 64'h00ff, 3'd0, 5, "backpressure");

        // Flush on the third BUSY cycle, then immediately reissue
        valid_i     = 1'b1;
        op_i        = 2'd0;
        operand_a_i = 64'hdead_beef_0000_1111;
        operand_b_i = '1;
        trans_id_i  = 3'd2;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        repeat (2) begin @(posedge clk_i); #1; end
        flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        chk("flush_busy/valid", 64'(valid_o), 64'd0);
        chk("flush_busy/ready", 64'(ready_o), 64'd1);
        run_op(2'd0, 64'h2, 64'h2, 3'd3, 0, "after_flush");

        // Flush with valid in IDLE: nothing accepted
        valid_i = 1'b1;
        flush_i = 1'b1;
        operand_b_i = 64'h1;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        flush_i = 1'b0;
        chk("flush_idle/ready", 64'(ready_o), 64'd1);
        repeat (3) begin @(posedge clk_i); #1; end
        chk("flush_idle/valid", 64'(valid_o), 64'd0);

        // Asynchronous reset in the middle of BUSY
        valid_i     = 1'b1;
        op_i        = 2'd1;
        operand_a_i = '1;
        operand_b_i = '1;
        trans_id_i  = 3'd6;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        @(posedge clk_i); #1;
        rst_ni = 1'b0;
        #1;
        chk("rst_mid/valid", 64'(valid_o), 64'd0);
        chk("rst_mid/ready", 64'(ready_o), 64'd1);
        chk("rst_mid/tid", 64'(trans_id_o), 64'd0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        run_op(2'd0, 64'hffff_0000_aaaa_5555, 64'd0, 3'd1, 0, "b_zero");

        // Randomized operands with varied B widths and backpressure
        for (int n = 0; n < 40; n++) begin
            a    = {$urandom, $urandom};
            mask = (64'd1 << (BPC * $urandom_range(0, NCHUNK))) - 64'd1;
            b    = {$urandom, $urandom} & mask;
            run_op(2'($urandom_range(0, 3)), a, b, 3'($urandom), $urandom_range(0, 3), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_clmul_iter.md
Name: alu_clmul_iter

Overview:
- Iterative carry-less multiply unit for Zbc (CLMUL, CLMULH, CLMULR), placed beside the single-cycle ALU in the execute stage.
- Processes BITS_PER_CYCLE bits of operand B per cycle into a 2*XLEN accumulator.
- Uses a valid/ready issue handshake and a valid/ready result handshake, carries a transaction ID, supports flush, and terminates early once the remaining B bits are zero.

Parameters:
- XLEN, 64, datapath width; 32 or 64.
- BITS_PER_CYCLE, 8, B bits consumed per cycle; power of 2 dividing XLEN. NCHUNK = XLEN/BITS_PER_CYCLE.
- TRANS_ID_BITS, 3, width of the scoreboard transaction tag.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset.
- flush_i  in  1  kill in-flight or pending operation.
- valid_i  in  1  issue request.
- ready_o  out  1  unit can accept an issue.
- op_i  in  2  0=CLMUL, 1=CLMULH, 2=CLMULR, 3=reserved.
- operand_a_i  in  XLEN  rs1.
- operand_b_i  in  XLEN  rs2.
- trans_id_i  in  TRANS_ID_BITS  issue tag.
- valid_o  out  1  result valid.
- ready_i  in  1  writeback accepts result.
- result_o  out  XLEN  result.
- trans_id_o  out  TRANS_ID_BITS  tag of result.

Behaviour:
- Clocking/reset: one clock, clk_i; reset rst_ni is asynchronous, active-low.
- Reset values:
  - state=IDLE.
  - valid_o=0, result_o=0, trans_id_o=0.
  - accumulator, operand, op, tag and chunk-counter registers all 0.
  - ready_o=1, since it is decoded from IDLE.
- Math:
  - P = XOR over i in 0..XLEN-1 of ((A zero-extended to 2*XLEN) << i) where B[i]=1.
  - CLMUL result = P[XLEN-1:0].
  - CLMULH result = P[2*XLEN-1:XLEN].
  - CLMULR result = P[2*XLEN-2:XLEN-1].
  - op_i=3 yields result 0 with normal handshake and latency.
- States:
  - IDLE: ready_o=1, valid_o=0. On valid_i & ~flush_i: latch A, B, op, tag; clear accumulator and chunk counter c; go to BUSY.
  - BUSY: ready_o=0. Each cycle XORs (A << (c*BITS_PER_CYCLE+k)) into the accumulator for each k in 0..BITS_PER_CYCLE-1 where B[c*BITS_PER_CYCLE+k]=1. Then:
    - go to DONE if c==NCHUNK-1, or if B bits above chunk c are all zero (early termination);
    - otherwise c <= c+1.
  - DONE: valid_o=1. result_o is the selected slice of the accumulator, registered on entry and stable. trans_id_o is the latched tag. On ready_i go to IDLE, and valid_o drops the next cycle.
- Latency:
  - L = max(1, index of highest nonzero chunk of B + 1), so 1 ≤ L ≤ NCHUNK.
  - valid_o rises L cycles after the accept edge.
  - B=0 gives L=1 and result 0.
- No back-to-back accept: IDLE is re-entered after the result handshake, so the minimum initiation interval is L+2.
- result_o=0 whenever valid_o=0.
- Flush:
  - flush_i in any state forces IDLE at the next edge; valid_o=0 and the result is discarded.
  - flush_i has priority over valid_i in the same cycle: no accept.
  - flush_i in DONE together with ready_i: the result counts as not delivered; writeback ignores it by rule.
- Handshake rules:
  - valid_o, result_o and trans_id_o are stable while valid_o & ~ready_i.
  - ready_i is ignored outside DONE.
  - Inputs are sampled only on the accept cycle; changes during BUSY have no effect.
- Reset mid-operation: asynchronous return to reset values regardless of state.

Test Plan:
- CLMUL, A=0x3, B=0x3 → result_o=0x5, valid_o 1 cycle after accept (early termination), trans_id_o echoes trans_id_i=5.
- CLMULH, A=B=0xFFFF_FFFF_FFFF_FFFF → 0x5555_5555_5555_5555 after 8 cycles. Same operands with CLMUL → 0x5555_5555_5555_5555; with CLMULR → 0xAAAA_AAAA_AAAA_AAAA.
- CLMUL, A=0x8000_0000_0000_0001, B=0x0100_0000_0000_0000:
  - CLMUL → 0x0100_0000_0000_0000;
  - CLMULH → 0x0080_0000_0000_0000;
  - latency 8 (top chunk nonzero).
- Backpressure: hold ready_i=0 for 5 cycles in DONE → valid_o, result_o and trans_id_o constant, ready_o=0 throughout; ready_i=1 → IDLE, ready_o=1 next cycle.
- Flush on the 3rd BUSY cycle with B all ones → no valid_o ever. A new issue (CLMUL A=0x2, B=0x2) the following cycle → 0x4. Also: flush_i with valid_i in IDLE → no accept.
- rst_ni asserted mid-BUSY → valid_o=0, ready_o=1 immediately. B=0 issue after release → result 0, latency 1.
